// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory path: access-size encodings, dmem FSM states,
// and the lane helpers used when a request is accepted.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } dmem_state_e;

  // Encoding 2'b11 behaves exactly like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Pure combinational: pulls the addressed byte/half out of a memory word and sign- or
// zero-extends it; word loads pass straight through.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    if (size == SZ_BYTE) begin
      data = ld_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (size == SZ_HALF) begin
      data = ld_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end else begin
      data = rdata;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller: accepts one aligned access from the core, runs a req/ack memory
// handshake, stalls the core for 2+ cycles, aborts after TIMEOUT_CYCLES without ack.
module dmem_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned,
  output logic        timeout,
  output logic        m_req,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        to_flag_q, to_flag_d;

  logic        req;
  logic        fault;
  logic [31:0] load_val;

  load_extend u_load_extend (
    .rdata       (m_rdata),
    .size        (size_q),
    .addr_lo     (lo_q),
    .ld_unsigned (uns_q),
    .data        (load_val)
  );

  assign req   = memread | memwrite;
  assign fault = is_misaligned(size, addr[1:0]);

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    size_d     = size_q;
    uns_d      = uns_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    to_flag_d  = to_flag_q;
    stall      = 1'b0;
    misaligned = 1'b0;
    timeout    = 1'b0;
    m_req      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && fault) begin
          misaligned = 1'b1;
          rdata_d    = '0;
        end else if (req) begin
          stall     = 1'b1;
          state_d   = ST_ACCESS;
          we_d      = memwrite;
          addr_d    = addr[31:2];
          lo_d      = addr[1:0];
          size_d    = size;
          uns_d     = ld_unsigned;
          be_d      = lane_be(size, addr[1:0]);
          wdata_d   = lane_wdata(size, writedata);
          cnt_d     = '0;
          to_flag_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        m_req = 1'b1;
        stall = 1'b1;
        // An ack arriving on the final allowed cycle still completes normally.
        if (m_ack) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = load_val;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          to_flag_d = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        timeout = to_flag_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      lo_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign readdata = rdata_q;
  assign m_we     = we_q;
  assign m_addr   = addr_q;
  assign m_be     = be_q;
  assign m_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT_CYCLES=4: loads, stores, alignment faults,
// timeout abort and reset mid-access, all against hand-computed values.
module tb_dmem_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, writedata, readdata, m_wdata, m_rdata;
  logic        stall, misaligned, timeout, m_req, m_we, m_ack;
  logic [29:0] m_addr;
  logic [3:0]  m_be;

  int n_chk  = 0;
  int n_pass = 0;

  int          cap_stalls, cap_reqs;
  logic        cap_we, cap_to, cap_hung;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [29:0] cap_addr;

  dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .size(size),
    .ld_unsigned(ld_unsigned), .addr(addr), .writedata(writedata), .readdata(readdata),
    .stall(stall), .misaligned(misaligned), .timeout(timeout), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one access and run it until stall drops; ack_after<0 means never ack.
  task automatic xfer(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                      input int ack_after);
    cap_stalls = 0; cap_reqs = 0; cap_hung = 1'b1;
    cap_be = '0; cap_wdata = '0; cap_addr = '0; cap_we = 1'b0; cap_to = 1'b0;
    memread = rd; memwrite = wr; size = sz; ld_unsigned = uns; addr = a; writedata = wd;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!stall) begin
        cap_hung = 1'b0;
        cap_to   = timeout;
        break;
      end
      cap_stalls++;
      if (m_req) begin
        cap_be = m_be; cap_wdata = m_wdata; cap_addr = m_addr; cap_we = m_we;
        if (cap_reqs == ack_after) begin
          m_ack = 1'b1; m_rdata = rdat;
        end
        cap_reqs++;
      end
      tick();
      m_ack = 1'b0;
      #1;
    end
    chk("no_hang", 32'(cap_hung), 32'd0);
    memread = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memread = 0; memwrite = 0; size = 0; ld_unsigned = 0;
    addr = 0; writedata = 0; m_rdata = 0; m_ack = 0;
    repeat (3) tick();
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_flags", {29'd0, stall, misaligned, timeout}, 32'd0);
    reset = 1'b0;
    tick();

    // lb 0x1003, lane 3 = 0x80 sign-extended
    xfer(1, 0, SZ_BYTE, 0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    chk("lb_stalls", 32'(cap_stalls), 32'd2);
    chk("lb_be", 32'(cap_be), 32'h8);
    chk("lb_addr", 32'(cap_addr), 32'h400);
    chk("lb_we", 32'(cap_we), 32'd0);
    chk("lb_data", readdata, 32'hFFFF_FF80);
    chk("lb_done_req", 32'(m_req), 32'd0);
    tick();

    xfer(1, 0, SZ_HALF, 1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0);
    chk("lhu_be", 32'(cap_be), 32'hC);
    chk("lhu_data", readdata, 32'h0000_BEEF);
    chk("lhu_stalls", 32'(cap_stalls), 32'd2);
    tick();

    // Store leaves readdata untouched
    xfer(0, 1, SZ_BYTE, 0, 32'h0000_0001, 32'h0000_00A5, 32'h0, 0);
    chk("sb_we", 32'(cap_we), 32'd1);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", 32'(cap_addr), 32'd0);
    chk("sb_keep_rd", readdata, 32'h0000_BEEF);
    tick();

    // lh with ack on the third ACCESS cycle
    xfer(1, 0, SZ_HALF, 0, 32'h0000_0040, 32'h0, 32'h0000_8001, 2);
    chk("lh_slow_stalls", 32'(cap_stalls), 32'd4);
    chk("lh_slow_reqs", 32'(cap_reqs), 32'd3);
    chk("lh_slow_data", readdata, 32'hFFFF_8001);
    tick();

    // read+write together is a write
    xfer(1, 1, SZ_WORD, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 0);
    chk("rw_we", 32'(cap_we), 32'd1);
    chk("rw_be", 32'(cap_be), 32'hF);
    chk("rw_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("rw_addr", 32'(cap_addr), 32'h4);
    chk("rw_keep_rd", readdata, 32'hFFFF_8001);
    tick();

    xfer(0, 1, SZ_HALF, 0, 32'h0000_0002, 32'h1234_5678, 32'h0, 0);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'h5678_5678);
    tick();

    // size 11 acts as word
    xfer(1, 0, 2'b11, 0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 0);
    chk("sz3_be", 32'(cap_be), 32'hF);
    chk("sz3_data", readdata, 32'hCAFE_F00D);
    tick();

    // lw 0x0006 faults
    memread = 1; size = SZ_WORD; addr = 32'h0000_0006; ld_unsigned = 0;
    #1;
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req", 32'(m_req), 32'd0);
    tick();
    memread = 0;
    #1;
    chk("mis_data", readdata, 32'd0);
    chk("mis_req2", 32'(m_req), 32'd0);
    chk("mis_clear", 32'(misaligned), 32'd0);
    memread = 1; size = SZ_HALF; addr = 32'h0000_0001;
    #1;
    chk("mis_half", 32'(misaligned), 32'd1);
    chk("mis_half_stall", 32'(stall), 32'd0);
    tick();
    memread = 0;

    // load 0xFF so the timeout's zeroing is visible
    xfer(1, 0, SZ_BYTE, 1, 32'h0000_0000, 32'h0, 32'h0000_00FF, 0);
    chk("lbu_data", readdata, 32'h0000_00FF);
    tick();

    xfer(1, 0, SZ_WORD, 0, 32'h0000_0008, 32'h0, 32'h0, -1);
    chk("to_reqs", 32'(cap_reqs), 32'd4);
    chk("to_stalls", 32'(cap_stalls), 32'd5);
    chk("to_pulse", 32'(cap_to), 32'd1);
    chk("to_data", readdata, 32'd0);
    tick();
    chk("to_clear", 32'(timeout), 32'd0);
    chk("to_idle_stall", 32'(stall), 32'd0);

    // ack while idle must be ignored
    xfer(1, 0, SZ_WORD, 0, 32'h0000_0000, 32'h0, 32'h7777_0001, 0);
    tick();
    m_ack = 1; m_rdata = 32'h5555_5555;
    tick();
    m_ack = 0;
    #1;
    chk("idle_ack_data", readdata, 32'h7777_0001);
    chk("idle_ack_req", 32'(m_req), 32'd0);

    // reset in the 2nd ACCESS cycle, ack one cycle later
    memread = 1; size = SZ_WORD; addr = 32'h0000_000C;
    tick();
    tick();
    #1;
    chk("rst_acc2_req", 32'(m_req), 32'd1);
    reset = 1;
    tick();
    reset = 0; memread = 0; m_ack = 1; m_rdata = 32'h1111_1111;
    #1;
    chk("rst_acc_req", 32'(m_req), 32'd0);
    chk("rst_acc_data", readdata, 32'd0);
    chk("rst_acc_stall", 32'(stall), 32'd0);
    tick();
    m_ack = 0;
    #1;
    chk("late_ack_data", readdata, 32'd0);
    chk("late_ack_req", 32'(m_req), 32'd0);
    chk("late_ack_to", 32'(timeout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
